// File: rtl/lsu_mem_arbiter_if.sv
// lsu_mem_arbiter_if: bundle of read/write request/completion signals for a set of ports.
// The same bundle is used on the LSU side (one port per LSU) and on the memory side
// (one port per channel).
//   master: drives read/write valid, address and write data; receives ready and read data.
//   slave : receives requests; drives ready pulses and read data.
interface lsu_mem_arbiter_if #(
    parameter int unsigned NUM_PORTS  = 1,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [NUM_PORTS-1:0]                 read_valid;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] read_address;
    logic [NUM_PORTS-1:0]                 read_ready;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] read_data;
    logic [NUM_PORTS-1:0]                 write_valid;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] write_address;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] write_data;
    logic [NUM_PORTS-1:0]                 write_ready;

    modport master (
        output read_valid, read_address, write_valid, write_address, write_data,
        input  read_ready, read_data, write_ready
    );

    modport slave (
        input  read_valid, read_address, write_valid, write_address, write_data,
        output read_ready, read_data, write_ready
    );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: arbitrates NUM_VECTOR_LSUS thread LSUs plus one scalar LSU (index
// NUM_VECTOR_LSUS) onto DATA_MEM_NUM_CHANNELS memory channels. Each channel holds a
// registered grant until its memory handshake completes. Vector addresses are
// partition-local and translated into per-thread windows above TL_BASE_ADDR; an
// out-of-partition access completes immediately with no memory traffic and raises a
// sticky fault.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   scalar_priority_en  1: scalar first with streak limit; 0: scalar joins round robin
//   lsu                 LSU-side request/completion bundle (NUM_VECTOR_LSUS+1 ports)
//   mem                 memory-side request/completion bundle (one port per channel)
//   fault, fault_idx    sticky fault flag and requester index of the first fault
module lsu_mem_arbiter #(
    parameter int unsigned           NUM_VECTOR_LSUS       = 16,
    parameter int unsigned           DATA_MEM_NUM_CHANNELS = 2,
    parameter int unsigned           ADDR_WIDTH            = 32,
    parameter int unsigned           DATA_WIDTH            = 32,
    parameter logic [ADDR_WIDTH-1:0] TL_BASE_ADDR          = 32'h0000_8000,
    parameter int unsigned           TL_PARTITION_WORDS    = 256,
    parameter int unsigned           MAX_SCALAR_STREAK     = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   scalar_priority_en,
    lsu_mem_arbiter_if.slave                       lsu,
    lsu_mem_arbiter_if.master                      mem,
    output logic                                   fault,
    output logic [$clog2(NUM_VECTOR_LSUS+1)-1:0]   fault_idx
);
    localparam int unsigned NUM_LSUS = NUM_VECTOR_LSUS + 1;
    localparam int unsigned CH       = DATA_MEM_NUM_CHANNELS;
    localparam int unsigned IDX_W    = $clog2(NUM_LSUS);
    localparam int unsigned RR_W     = IDX_W + 1;
    localparam int unsigned STREAK_W = $clog2(MAX_SCALAR_STREAK + 1);
    localparam logic [IDX_W-1:0]      SCALAR_IDX = IDX_W'(NUM_VECTOR_LSUS);
    localparam logic [STREAK_W-1:0]   STREAK_MAX = STREAK_W'(MAX_SCALAR_STREAK);
    localparam logic [ADDR_WIDTH-1:0] PART_WORDS = ADDR_WIDTH'(TL_PARTITION_WORDS);

    typedef enum logic [1:0] {StIdle, StBusy, StFault} ch_state_e;

    ch_state_e             state_q [CH];
    ch_state_e             state_d [CH];
    logic [IDX_W-1:0]      idx_q   [CH];
    logic [IDX_W-1:0]      idx_d   [CH];
    logic [ADDR_WIDTH-1:0] addr_q  [CH];
    logic [ADDR_WIDTH-1:0] addr_d  [CH];
    logic [DATA_WIDTH-1:0] wdata_q [CH];
    logic [DATA_WIDTH-1:0] wdata_d [CH];
    logic [CH-1:0]         is_write_q, is_write_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic                  fault_q, fault_d;
    logic [IDX_W-1:0]      fault_idx_q, fault_idx_d;

    // Allocation temporaries
    logic [NUM_LSUS-1:0]   taken, elig;
    logic [RR_W-1:0]       rr_size, rr_start, cand, next_ptr;
    logic [IDX_W-1:0]      pick;
    logic                  found, vec_any, vec_granted, scalar_bump, pick_write;
    logic [ADDR_WIDTH-1:0] local_addr;

    assign fault     = fault_q;
    assign fault_idx = fault_idx_q;

    always_comb begin
        taken       = '0;
        elig        = '0;
        cand        = '0;
        next_ptr    = '0;
        pick        = '0;
        found       = 1'b0;
        vec_any     = 1'b0;
        vec_granted = 1'b0;
        scalar_bump = 1'b0;
        pick_write  = 1'b0;
        local_addr  = '0;
        rr_ptr_d    = rr_ptr_q;
        streak_d    = streak_q;
        fault_d     = fault_q;
        fault_idx_d = fault_idx_q;
        is_write_d  = is_write_q;
        for (int unsigned c = 0; c < CH; c++) begin
            state_d[c] = state_q[c];
            idx_d[c]   = idx_q[c];
            addr_d[c]  = addr_q[c];
            wdata_d[c] = wdata_q[c];
            if (state_q[c] != StIdle) taken[idx_q[c]] = 1'b1;
        end

        rr_size  = scalar_priority_en ? RR_W'(NUM_VECTOR_LSUS) : RR_W'(NUM_LSUS);
        // Pointer may be out of range right after a mode switch
        rr_start = ({1'b0, rr_ptr_q} < rr_size) ? {1'b0, rr_ptr_q} : '0;

        for (int unsigned c = 0; c < CH; c++) begin
            case (state_q[c])
                StBusy: begin
                    if (is_write_q[c] ? mem.write_ready[c] : mem.read_ready[c]) begin
                        state_d[c] = StIdle;
                    end
                end
                StFault: state_d[c] = StIdle;
                default: begin
                    elig    = (lsu.read_valid | lsu.write_valid) & ~taken;
                    vec_any = |elig[NUM_VECTOR_LSUS-1:0];
                    found   = 1'b0;
                    pick    = '0;
                    if (scalar_priority_en && elig[SCALAR_IDX] &&
                        !(streak_q == STREAK_MAX && vec_any)) begin
                        found = 1'b1;
                        pick  = SCALAR_IDX;
                    end else begin
                        for (int unsigned k = 0; k < NUM_LSUS; k++) begin
                            cand = rr_start + RR_W'(k);
                            if (cand >= rr_size) cand = cand - rr_size;
                            if (!found && RR_W'(k) < rr_size && elig[IDX_W'(cand)]) begin
                                found = 1'b1;
                                pick  = IDX_W'(cand);
                            end
                        end
                    end
                    if (found) begin
                        taken[pick] = 1'b1;
                        // Read wins when both are pending; the write follows later
                        pick_write    = !lsu.read_valid[pick];
                        local_addr    = pick_write ? lsu.write_address[pick]
                                                   : lsu.read_address[pick];
                        idx_d[c]      = pick;
                        is_write_d[c] = pick_write;
                        wdata_d[c]    = lsu.write_data[pick];
                        if (pick == SCALAR_IDX) begin
                            addr_d[c]  = local_addr;
                            state_d[c] = StBusy;
                        end else if (local_addr >= PART_WORDS) begin
                            addr_d[c]  = '0;
                            state_d[c] = StFault;
                            if (!fault_d) begin
                                fault_d     = 1'b1;
                                fault_idx_d = pick;
                            end
                        end else begin
                            addr_d[c]  = TL_BASE_ADDR + ADDR_WIDTH'(pick) * PART_WORDS +
                                         local_addr;
                            state_d[c] = StBusy;
                        end
                        if (!scalar_priority_en || pick != SCALAR_IDX) begin
                            next_ptr = {1'b0, pick} + 1'b1;
                            rr_ptr_d = (next_ptr == rr_size) ? '0 : IDX_W'(next_ptr);
                        end
                        if (pick != SCALAR_IDX) vec_granted = 1'b1;
                        else if (vec_any)       scalar_bump = 1'b1;
                    end
                end
            endcase
        end

        if (vec_granted) begin
            streak_d = '0;
        end else if (scalar_bump && streak_q != STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
        end
    end

    // Memory requests and LSU completions; completion is combinational from mem ready.
    always_comb begin
        mem.read_valid    = '0;
        mem.read_address  = '0;
        mem.write_valid   = '0;
        mem.write_address = '0;
        mem.write_data    = '0;
        lsu.read_ready    = '0;
        lsu.read_data     = '0;
        lsu.write_ready   = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            if (state_q[c] == StBusy) begin
                if (is_write_q[c]) begin
                    mem.write_valid[c]   = 1'b1;
                    mem.write_address[c] = addr_q[c];
                    mem.write_data[c]    = wdata_q[c];
                    if (mem.write_ready[c]) lsu.write_ready[idx_q[c]] = 1'b1;
                end else begin
                    mem.read_valid[c]   = 1'b1;
                    mem.read_address[c] = addr_q[c];
                    if (mem.read_ready[c]) begin
                        lsu.read_ready[idx_q[c]] = 1'b1;
                        lsu.read_data[idx_q[c]]  = mem.read_data[c];
                    end
                end
            end else if (state_q[c] == StFault) begin
                // Faulted access completes at once: reads return 0, writes are dropped
                if (is_write_q[c]) lsu.write_ready[idx_q[c]] = 1'b1;
                else               lsu.read_ready[idx_q[c]]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < CH; c++) begin
                state_q[c] <= StIdle;
                idx_q[c]   <= '0;
                addr_q[c]  <= '0;
                wdata_q[c] <= '0;
            end
            is_write_q  <= '0;
            rr_ptr_q    <= '0;
            streak_q    <= '0;
            fault_q     <= 1'b0;
            fault_idx_q <= '0;
        end else begin
            for (int unsigned c = 0; c < CH; c++) begin
                state_q[c] <= state_d[c];
                idx_q[c]   <= idx_d[c];
                addr_q[c]  <= addr_d[c];
                wdata_q[c] <= wdata_d[c];
            end
            is_write_q  <= is_write_d;
            rr_ptr_q    <= rr_ptr_d;
            streak_q    <= streak_d;
            fault_q     <= fault_d;
            fault_idx_q <= fault_idx_d;
        end
    end
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench for lsu_mem_arbiter: dut_a has one channel, dut_b has two.
module tb_lsu_mem_arbiter;
    localparam int unsigned NV          = 16;
    localparam int unsigned NL          = NV + 1;
    localparam logic [31:0] SCALAR_ADDR = 32'h0000_0100;

    logic       clk = 1'b0;
    logic       reset;
    logic       scalar_priority_en;
    logic       fault_a, fault_b;
    logic [4:0] fault_idx_a, fault_idx_b;
    int         total = 0;
    int         bad = 0;
    int         who;
    int         rr_exp [4]  = '{0, 1, 15, 0};
    int         st_exp [10] = '{16, 16, 16, 16, 2, 16, 16, 16, 16, 2};

    always #5 clk = ~clk;

    lsu_mem_arbiter_if #(.NUM_PORTS(NL), .ADDR_WIDTH(32), .DATA_WIDTH(32)) lsu_a ();
    lsu_mem_arbiter_if #(.NUM_PORTS(1),  .ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_a ();
    lsu_mem_arbiter_if #(.NUM_PORTS(NL), .ADDR_WIDTH(32), .DATA_WIDTH(32)) lsu_b ();
    lsu_mem_arbiter_if #(.NUM_PORTS(2),  .ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_b ();

    lsu_mem_arbiter #(.NUM_VECTOR_LSUS(NV), .DATA_MEM_NUM_CHANNELS(1)) dut_a (
        .clk(clk), .reset(reset), .scalar_priority_en(scalar_priority_en),
        .lsu(lsu_a), .mem(mem_a), .fault(fault_a), .fault_idx(fault_idx_a)
    );

    lsu_mem_arbiter #(.NUM_VECTOR_LSUS(NV), .DATA_MEM_NUM_CHANNELS(2)) dut_b (
        .clk(clk), .reset(reset), .scalar_priority_en(scalar_priority_en),
        .lsu(lsu_b), .mem(mem_b), .fault(fault_b), .fault_idx(fault_idx_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        lsu_a.read_valid = '0; lsu_a.read_address = '0; lsu_a.write_valid = '0;
        lsu_a.write_address = '0; lsu_a.write_data = '0;
        lsu_b.read_valid = '0; lsu_b.read_address = '0; lsu_b.write_valid = '0;
        lsu_b.write_address = '0; lsu_b.write_data = '0;
        mem_a.read_ready = '0; mem_a.write_ready = '0; mem_a.read_data = '0;
        mem_b.read_ready = '0; mem_b.write_ready = '0; mem_b.read_data = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Waits (bounded) for dut_a's read grant, decodes the requester from the address,
    // completes it with a one-cycle memory response. who = -1 on timeout.
    task automatic serve_a(output int got_who);
        int          n;
        logic [31:0] addr;
        n       = 0;
        got_who = -1;
        while (mem_a.read_valid[0] !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        if (mem_a.read_valid[0] === 1'b1) begin
            addr    = mem_a.read_address[0];
            got_who = (addr == SCALAR_ADDR) ? int'(NV) : int'((addr - 32'h8000) >> 8);
            mem_a.read_ready[0] = 1'b1;
            step();
            mem_a.read_ready[0] = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        scalar_priority_en = 1'b1;
        do_reset();
        check("rst_mem_rv", mem_a.read_valid, 0);
        check("rst_mem_wv", mem_a.write_valid, 0);
        check("rst_mem_addr", mem_a.read_address[0], 0);
        check("rst_lsu_rready", lsu_a.read_ready, 0);
        check("rst_fault", fault_a, 0);
        check("rst_fault_idx", fault_idx_a, 0);
        check("rst_b_rv", mem_b.read_valid, 0);

        // Single vector read: LSU3 local 5
        lsu_a.read_valid[3] = 1'b1; lsu_a.read_address[3] = 32'd5;
        #1 check("t1_no_early_rv", mem_a.read_valid, 0);
        step();
        check("t1_rv", mem_a.read_valid, 1);
        check("t1_addr", mem_a.read_address[0], 32'h8305);
        mem_a.read_ready[0] = 1'b1; mem_a.read_data[0] = 32'hDEAD;
        #1 check("t1_rready", lsu_a.read_ready, 17'h8);
        check("t1_rdata", lsu_a.read_data[3], 32'hDEAD);
        check("t1_rdata_other", lsu_a.read_data[2], 0);
        step();
        lsu_a.read_valid[3] = 1'b0; mem_a.read_ready[0] = 1'b0;
        #1 check("t1_idle_rv", mem_a.read_valid, 0);
        check("t1_rready_off", lsu_a.read_ready, 0);

        // Read and write pending together: read first, then write
        do_reset();
        lsu_a.read_valid[4] = 1'b1;  lsu_a.read_address[4] = 32'd1;
        lsu_a.write_valid[4] = 1'b1; lsu_a.write_address[4] = 32'd2;
        lsu_a.write_data[4] = 32'hBEEF;
        step();
        check("rw_read_first", {mem_a.write_valid, mem_a.read_valid}, 2'b01);
        check("rw_raddr", mem_a.read_address[0], 32'h8401);
        mem_a.read_ready[0] = 1'b1; mem_a.read_data[0] = 32'h1234;
        #1 check("rw_rready", lsu_a.read_ready, 17'h10);
        check("rw_wready_quiet", lsu_a.write_ready, 0);
        step();
        lsu_a.read_valid[4] = 1'b0; mem_a.read_ready[0] = 1'b0;
        #1 check("rw_gap", mem_a.write_valid, 0);
        step();
        check("rw_wv", mem_a.write_valid, 1);
        check("rw_waddr", mem_a.write_address[0], 32'h8402);
        check("rw_wdata", mem_a.write_data[0], 32'hBEEF);
        mem_a.write_ready[0] = 1'b1;
        #1 check("rw_wready", lsu_a.write_ready, 17'h10);
        step();
        lsu_a.write_valid[4] = 1'b0; mem_a.write_ready[0] = 1'b0;

        // Round robin among LSUs 0, 1, 15
        do_reset();
        lsu_a.read_valid[0] = 1'b1; lsu_a.read_valid[1] = 1'b1; lsu_a.read_valid[15] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve_a(who);
            check($sformatf("rr_grant%0d", i), who, rr_exp[i]);
        end

        // Scalar streak limit against LSU2
        do_reset();
        lsu_a.read_valid[16] = 1'b1; lsu_a.read_address[16] = SCALAR_ADDR;
        lsu_a.read_valid[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            serve_a(who);
            check($sformatf("streak_grant%0d", i), who, st_exp[i]);
        end

        // Two channels: scalar and LSUs 0, 1
        do_reset();
        lsu_b.read_valid[16] = 1'b1; lsu_b.read_address[16] = SCALAR_ADDR;
        lsu_b.read_valid[0] = 1'b1; lsu_b.read_valid[1] = 1'b1;
        step();
        check("dual_both_valid", mem_b.read_valid, 2'b11);
        check("dual_ch0_scalar", mem_b.read_address[0], SCALAR_ADDR);
        check("dual_ch1_lsu0", mem_b.read_address[1], 32'h8000);
        mem_b.read_ready[1] = 1'b1; mem_b.read_data[1] = 32'h55;
        #1 check("dual_lsu0_ready", lsu_b.read_ready, 17'h1);
        step();
        lsu_b.read_valid[0] = 1'b0; mem_b.read_ready[1] = 1'b0;
        #1 check("dual_ch1_freed", mem_b.read_valid, 2'b01);
        step();
        check("dual_lsu1_valid", mem_b.read_valid, 2'b11);
        check("dual_lsu1_ch1", mem_b.read_address[1], 32'h8100);

        // Out-of-partition write by LSU7, later fault by LSU2
        do_reset();
        lsu_a.write_valid[7] = 1'b1; lsu_a.write_address[7] = 32'd256;
        lsu_a.write_data[7] = 32'h77;
        step();
        check("flt_no_wv", mem_a.write_valid, 0);
        check("flt_wready", lsu_a.write_ready, 17'h80);
        check("flt_set", fault_a, 1);
        check("flt_idx", fault_idx_a, 7);
        step();
        lsu_a.write_valid[7] = 1'b0;
        #1 check("flt_ready_once", lsu_a.write_ready, 0);
        lsu_a.read_valid[2] = 1'b1; lsu_a.read_address[2] = 32'd300;
        mem_a.read_data[0] = 32'hFFFF;
        step();
        check("flt2_rready", lsu_a.read_ready, 17'h4);
        check("flt2_rdata_zero", lsu_a.read_data[2], 0);
        check("flt2_no_rv", mem_a.read_valid, 0);
        check("flt_idx_sticky", fault_idx_a, 7);
        step();
        lsu_a.read_valid[2] = 1'b0;

        // Reset while a read is outstanding
        do_reset();
        lsu_a.read_valid[3] = 1'b1; lsu_a.read_address[3] = 32'd5;
        step();
        check("rmb_busy", mem_a.read_valid, 1);
        reset = 1'b1;
        step();
        check("rmb_rv_cleared", mem_a.read_valid, 0);
        check("rmb_addr_cleared", mem_a.read_address[0], 0);
        reset = 1'b0;
        lsu_a.read_valid[3] = 1'b0; mem_a.read_ready[0] = 1'b1;
        #1 check("rmb_stale_ready", lsu_a.read_ready, 0);
        step();
        mem_a.read_ready[0] = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
